// File: rtl/m_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : m_mem_arbiter
// Brief   : Two-requester arbiter (A has priority) sharing one single-port
//           memory; read data returns one cycle after the grant.
// Option  : define ARB_STARVE_GUARD_EN to bound B's wait to STARVE_MAX cycles.
// Rev     : 1.0  initial release
// ============================================================================
module m_mem_arbiter #(
    parameter int AW         = 11,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          w_clk,
    input  logic          w_rst,
    input  logic          w_a_req,
    input  logic          w_a_we,
    input  logic [AW-1:0] w_a_addr,
    input  logic [DW-1:0] w_a_wdata,
    output logic          w_a_gnt,
    output logic          r_a_rvalid,
    output logic [DW-1:0] w_a_rdata,
    input  logic          w_b_req,
    input  logic          w_b_we,
    input  logic [AW-1:0] w_b_addr,
    input  logic [DW-1:0] w_b_wdata,
    output logic          w_b_gnt,
    output logic          r_b_rvalid,
    output logic [DW-1:0] w_b_rdata,
    output logic [AW-1:0] w_m_addr,
    output logic          w_m_we,
    output logic [DW-1:0] w_m_din,
    input  logic [DW-1:0] w_m_dout,
    output logic [15:0]   r_conflicts
);

    logic w_both;
    logic w_b_force;

    assign w_both = w_a_req & w_b_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_MAX);

    logic [7:0] r_starve;

    assign w_b_force = (r_starve == c_STARVE_MAX);

    // Counts consecutive cycles B has been kept waiting; saturates at the limit.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_starve <= 8'd0;
        end else if (w_b_req & ~w_b_gnt) begin
            if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 8'd1;
            end
        end else begin
            r_starve <= 8'd0;
        end
    end
`else
    assign w_b_force = 1'b0;
`endif

    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (w_both) begin
            w_b_gnt = w_b_force;
            w_a_gnt = ~w_b_force;
        end else begin
            w_a_gnt = w_a_req;
            w_b_gnt = w_b_req;
        end
    end

    // With no grant the A address still drives the port, giving a harmless read.
    assign w_m_addr  = w_b_gnt ? w_b_addr  : w_a_addr;
    assign w_m_din   = w_b_gnt ? w_b_wdata : w_a_wdata;
    assign w_m_we    = (w_a_gnt & w_a_we) | (w_b_gnt & w_b_we);

    assign w_a_rdata = w_m_dout;
    assign w_b_rdata = w_m_dout;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_conflicts <= 16'd0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~w_a_we;
            r_b_rvalid <= w_b_gnt & ~w_b_we;
            if (w_both && (r_conflicts != 16'hffff)) begin
                r_conflicts <= r_conflicts + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire
